// File: rtl/mode_led_ind.sv
// mode_led_ind: blinks the active camera mode index+1 times on one LED, then holds a dark gap.
module mode_led_ind #(
  parameter logic c_on   = 1'b1,
  parameter int   c_half = 6_250_000,
  parameter int   c_gap  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rgbmode,
  input  logic       testmode,
  output logic       led,
  output logic       burst_start,
  output logic [1:0] mode_out
);
  localparam int TW = $clog2(c_half);
  localparam int GW = c_gap > 1 ? $clog2(c_gap) : 1;
  localparam logic [TW-1:0] T_LD = TW'(c_half - 1);
  localparam logic [GW-1:0] G_LD = GW'(c_gap - 1);
  typedef enum logic [1:0] {S_ON, S_OFF, S_GAP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0] blink_q, blink_d, mode_q, mode_d;
  logic led_q, led_d, burst_q, burst_d;
  logic [1:0] m;
  assign m = {testmode, ~rgbmode};
  always_comb begin
    state_d = state_q;
    timer_d = timer_q - TW'(1);
    gap_d   = gap_q;
    blink_d = blink_q;
    mode_d  = mode_q;
    burst_d = 1'b0;
    // a mode change abandons the burst and wins over any phase end
    if (m != mode_q) begin
      mode_d  = m;
      state_d = S_GAP;
      timer_d = T_LD;
      gap_d   = G_LD;
    end else if (timer_q == '0) begin
      timer_d = T_LD;
      case (state_q)
        S_ON:  state_d = S_OFF;
        S_OFF: begin
          if (blink_q != 2'd0) begin
            state_d = S_ON;
            blink_d = blink_q - 2'd1;
          end else begin
            state_d = S_GAP;
            gap_d   = G_LD;
          end
        end
        default: begin
          if (gap_q == '0) begin
            state_d = S_ON;
            blink_d = mode_q;
            burst_d = 1'b1;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
      endcase
    end
    led_d = state_d == S_ON ? c_on : ~c_on;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_GAP;
      timer_q <= T_LD;
      gap_q   <= G_LD;
      blink_q <= 2'd0;
      mode_q  <= 2'd0;
      led_q   <= ~c_on;
      burst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      blink_q <= blink_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      burst_q <= burst_d;
    end
  end
  assign led         = led_q;
  assign burst_start = burst_q;
  assign mode_out    = mode_q;
endmodule

// File: tb/tb_mode_led_ind.sv
// tb_mode_led_ind: scoreboard bench for mode_led_ind with c_half=4, c_gap=3, both LED polarities.
module tb_mode_led_ind;
  localparam int H = 4;
  localparam int G = 3;
  logic clk = 1'b0;
  logic rst, rgbmode, testmode;
  logic led, burst_start, led0, burst0;
  logic [1:0] mode_out, mode0;
  logic [3:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  mode_led_ind #(.c_on(1'b1), .c_half(H), .c_gap(G)) dut (
    .clk(clk), .rst(rst), .rgbmode(rgbmode), .testmode(testmode),
    .led(led), .burst_start(burst_start), .mode_out(mode_out));
  mode_led_ind #(.c_on(1'b0), .c_half(H), .c_gap(G)) dut0 (
    .clk(clk), .rst(rst), .rgbmode(rgbmode), .testmode(testmode),
    .led(led0), .burst_start(burst0), .mode_out(mode0));

  always #5 clk = ~clk;

  // expected {led, burst_start, mode_out} k cycles after the gap was entered
  function automatic logic [3:0] exp_of(input logic [1:0] me, input int k);
    int p, r, q;
    p = (2 * (int'(me) + 1) + G) * H;
    r = k % p;
    if (r < G * H) return {2'b00, me};
    q = r - G * H;
    return {((q / H) % 2) == 0, q == 0, me};
  endfunction

  task automatic chk(input logic [1:0] mi, input logic [1:0] me, input int k);
    rgbmode  = ~mi[0];
    testmode = mi[1];
    exp_q.push_back(exp_of(me, k));
  endtask

  task automatic run(input logic [1:0] mi, input logic [1:0] me, input int k0, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      chk(mi, me, k0 + i);
    end
  endtask

  task automatic now_chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      now_chk("active_high", {led, burst_start, mode_out}, e);
      now_chk("active_low", {led0, burst0, mode0}, {~e[3], e[2:0]});
    end
  end

  initial begin
    // mode 00 held through reset
    rst = 1'b0; rgbmode = 1'b1; testmode = 1'b0;
    exp_q.push_back(4'b0000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    chk(2'd0, 2'd0, 0);
    run(2'd0, 2'd0, 1, 60);
    // mode 11 from reset: mode_out follows one edge after release
    @(posedge clk); #1;
    rst = 1'b0; rgbmode = 1'b0; testmode = 1'b1;
    exp_q.push_back(4'b0000);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(4'b0000);
    run(2'd3, 2'd3, 0, 100);
    // switch to 01, then to 10 in the 2nd cycle of the second ON phase
    run(2'd1, 2'd3, 100, 1);
    run(2'd1, 2'd1, 0, 21);
    run(2'd2, 2'd1, 21, 1);
    // mode 10; change to 11 on the last OFF cycle with blinks remaining
    run(2'd2, 2'd2, 0, 55);
    run(2'd3, 2'd2, 55, 1);
    run(2'd3, 2'd3, 0, 14);
    // asynchronous reset mid-ON phase
    @(posedge clk); #2;
    now_chk("lit_before_reset", {led, led0, mode_out}, 4'b1011);
    rst = 1'b0; rgbmode = 1'b1; testmode = 1'b0;
    #1;
    now_chk("async_reset", {led, burst_start, mode_out}, 4'b0000);
    now_chk("async_reset_low", {led0, burst0, mode0}, 4'b1000);
    exp_q.push_back(4'b0000);
    @(posedge clk); #1;
    exp_q.push_back(4'b0000);
    @(posedge clk); #1;
    rst = 1'b1;
    chk(2'd0, 2'd0, 0);
    run(2'd0, 2'd0, 1, 40);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mode_led_ind.md
# mode_led_ind

Mode indicator for the OV7670 RGB/YUV 80x60 camera designs. It takes the `rgbmode`/`testmode` pair produced by the push-button mode selector and reports the active mode to the user on one LED as a repeating blink code: mode index + 1 blinks, then a dark gap. The selector turns a human action into a mode; this block turns the mode back into a human-readable signal. It sits next to the selector in the top level, in the same clock domain.

## Interface
- `c_on`, 1'b1: LED drive level for "lit". The LED is dark at `~c_on`.
- `c_half`, 6_250_000: clock cycles per blink phase (ON or OFF); must be ≥ 2. The default gives 125 ms at 50 MHz.
- `c_gap`, 6: number of phase lengths in the dark gap between bursts; must be ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rgbmode`  in  1  1 = RGB, 0 = YUV. Synchronous to `clk`.
- `testmode`  in  1  1 = camera test pattern. Synchronous to `clk`.
- `led`  out  1  blink-code LED drive.
- `burst_start`  out  1  one-cycle pulse on the first cycle of each burst's first ON phase.
- `mode_out`  out  2  latched mode index currently being displayed.

## Operation
- Mode index `m = {testmode, ~rgbmode}`:
  - 00 = RGB normal
  - 01 = YUV normal
  - 10 = RGB test
  - 11 = YUV test
- Blinks per burst: `n = m + 1`, i.e. 1..4.
- State machine:
  - S_ON: `led = c_on`.
  - S_OFF: `led = ~c_on`.
  - S_GAP: `led = ~c_on`.
- Phase timer: loaded with `c_half-1` on entry to S_ON and S_OFF, and on each gap sub-phase. It decrements every cycle; the phase ends on the cycle it reads 0. Its width is `$clog2(c_half)`.
- Blink counter: loaded with `n-1` when entering S_ON from S_GAP. It is decremented at the end of each S_OFF.
- Gap counter: loaded with `c_gap-1` on entry to S_GAP. It decrements at each phase end; S_GAP exits when it is 0 and the phase timer is 0.
- Transitions:
  - S_ON → S_OFF at phase end.
  - S_OFF → S_ON at phase end if the blink counter ≠ 0; otherwise S_OFF → S_GAP.
  - S_GAP → S_ON at gap end. `burst_start` pulses on the first S_ON cycle and the blink counter is loaded.
- Mode latch: `mode_out` is registered. Every cycle the live `m` is compared to `mode_out`.
- On a mismatch (mode change):
  - `mode_out <= m`.
  - State → S_GAP with a full gap reload and `led` dark.
  - This takes priority over any phase end in the same cycle.
  - The burst in progress is abandoned, never completed.
- Inputs that change and return within one cycle still trigger a restart; no debouncing is done here.

## Timing
- Reset (`rst` = 0, asynchronous, effective without a clock edge):
  - `led = ~c_on`, `burst_start = 0`, `mode_out = 2'b00`.
  - State S_GAP, gap counter `c_gap-1`, phase timer `c_half-1`, blink counter 0.
- After release, if the inputs encode a mode other than 00, the mode-change rule applies on the first edge.
- First ON cycle is `c_gap*c_half` cycles after the state enters S_GAP. `burst_start` is high on exactly that cycle.
- Each ON phase and each OFF phase lasts exactly `c_half` cycles; the gap lasts `c_gap*c_half` cycles.
- Burst period is `(2n + c_gap)*c_half` cycles, steady state, constant mode.
- Mode-change response:
  - `mode_out` and dark `led` are visible one cycle after the input change, registered.
  - The next `burst_start` follows `c_gap*c_half` cycles after that.
- `led`, `burst_start` and `mode_out` are all registered outputs.

## Test plan
- Parameters `c_half`=4, `c_gap`=3. Hold mode 00 (rgbmode=1, testmode=0) through reset, then release → `led` dark for 12 cycles, then `burst_start` for 1 cycle with `led` lit 4 cycles, dark 16; period 20; `mode_out`=00.
- rgbmode=0, testmode=1 from reset → `mode_out`=11 one cycle after release. Each burst is 4 lit phases of 4 cycles separated by 4 dark cycles, followed by a 12-cycle gap; period 44 cycles; `burst_start` once per 44.
- Mode 01 steady, then switch to 10 in the 2nd cycle of the second ON phase → next cycle: `led` dark and `mode_out`=10. No further lit cycles for 12 cycles, then `burst_start` and 3 blinks.
- Mode change arriving on the exact cycle an S_OFF phase ends with blinks remaining → no ON phase starts; full 12-cycle gap precedes the next burst.
- Assert `rst` low mid-ON phase, between clock edges → `led` goes dark and `mode_out`=00 immediately. After release the sequence restarts as in the first scenario.
- `c_on`=0, mode 00 → `led` is 1 at reset and during dark phases, 0 during the 4-cycle ON phase; timing identical to the first scenario.
